// File: rtl/otter_decode_stage_pkg.sv
// rtl/otter_decode_stage_pkg.sv - RV32I opcodes, control enums and decoded-control struct
package otter_decode_stage_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] MRET_INSN = 32'h3020_0073;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0, ALU_SLL = 4'h1, ALU_SLT = 4'h2, ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4, ALU_SRL = 4'h5, ALU_OR  = 4'h6, ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8, ALU_LUI = 4'h9, ALU_SRA = 4'hD
   } alu_fun_t;

   typedef enum logic [1:0] {SRCA_RS1 = 2'd0, SRCA_UIMM = 2'd1, SRCA_NRS1 = 2'd2} srca_t;

   typedef enum logic [2:0] {
      SRCB_RS2 = 3'd0, SRCB_IIMM = 3'd1, SRCB_SIMM = 3'd2, SRCB_PC = 3'd3, SRCB_CSR = 3'd4
   } srcb_t;

   typedef enum logic [2:0] {
      PC_PLUS4 = 3'd0, PC_JALR = 3'd1, PC_BRANCH = 3'd2, PC_JAL = 3'd3,
      PC_MTVEC = 3'd4, PC_MEPC = 3'd5
   } pc_sel_t;

   typedef enum logic [1:0] {RF_PC4 = 2'd0, RF_CSR = 2'd1, RF_MEM = 2'd2, RF_ALU = 2'd3} rf_sel_t;

   typedef struct packed {
      alu_fun_t alu_fun;
      srca_t    srca;
      srcb_t    srcb;
      pc_sel_t  pc_sel;
      rf_sel_t  rf_sel;
      logic     rf_we;
      logic     mem_we;
      logic     mem_rden2;
      logic     csr_we;
      logic     mret_exec;
      logic     int_taken;
      logic     illegal;
   } ctrl_t;

   // Interrupt trap replaces the captured instruction: vector to mtvec, no side effects.
   function automatic ctrl_t trap_ctrl();
      ctrl_t c;
      c           = '0;
      c.pc_sel    = PC_MTVEC;
      c.int_taken = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/otter_decode_stage_if.sv
// rtl/otter_decode_stage_if.sv - fetch-side and execute-side signals of the decode stage
interface otter_decode_stage_if #(
   parameter int ALU_FUN_W = 4,
   parameter int PC_SEL_W  = 3
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          ir;
   logic                 br_eq;
   logic                 br_lt;
   logic                 br_ltu;
   logic                 int_req;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [ALU_FUN_W-1:0] alu_fun;
   logic [1:0]           srca_sel;
   logic [2:0]           srcb_sel;
   logic [PC_SEL_W-1:0]  pc_sel;
   logic [1:0]           rf_sel;
   logic                 rf_we;
   logic                 mem_we;
   logic                 mem_rden2;
   logic                 csr_we;
   logic                 mret_exec;
   logic                 int_taken;
   logic                 illegal;

   modport slave (
      input  in_valid, ir, br_eq, br_lt, br_ltu, int_req, flush, out_ready,
      output in_ready, out_valid, alu_fun, srca_sel, srcb_sel, pc_sel, rf_sel,
             rf_we, mem_we, mem_rden2, csr_we, mret_exec, int_taken, illegal
   );

   modport master (
      output in_valid, ir, br_eq, br_lt, br_ltu, int_req, flush, out_ready,
      input  in_ready, out_valid, alu_fun, srca_sel, srcb_sel, pc_sel, rf_sel,
             rf_we, mem_we, mem_rden2, csr_we, mret_exec, int_taken, illegal
   );
endinterface

// File: rtl/otter_decode_stage_comb.sv
// rtl/otter_decode_stage_comb.sv - pure combinational RV32I/CSR decode into ctrl_t
module otter_decode_comb
   import otter_decode_stage_pkg::*;
#(
   parameter bit EN_CSR = 1'b1
) (
   input  logic [31:0] i_ir,
   input  logic        i_br_eq,
   input  logic        i_br_lt,
   input  logic        i_br_ltu,
   output ctrl_t       o_ctrl
);
   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_taken;

   assign w_opcode = i_ir[6:0];
   assign w_f3     = i_ir[14:12];
   assign w_f7     = i_ir[31:25];

   always_comb begin
      o_ctrl  = '0;
      w_taken = 1'b0;
      case (w_opcode)
         OP_REG: begin
            if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
               o_ctrl.alu_fun = alu_fun_t'({i_ir[30], w_f3});
               o_ctrl.rf_sel  = RF_ALU;
               o_ctrl.rf_we   = 1'b1;
            end else begin
               o_ctrl.illegal = 1'b1;
            end
         end
         OP_IMM: begin
            // Only the shift-immediates constrain funct7; ir[30] selects sra vs srl.
            if ((w_f3 == 3'b001 && w_f7 != 7'h00) ||
                (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20)) begin
               o_ctrl.illegal = 1'b1;
            end else begin
               o_ctrl.alu_fun = alu_fun_t'({(w_f3 == 3'b101) ? i_ir[30] : 1'b0, w_f3});
               o_ctrl.srcb    = SRCB_IIMM;
               o_ctrl.rf_sel  = RF_ALU;
               o_ctrl.rf_we   = 1'b1;
            end
         end
         OP_LOAD: begin
            if (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
               o_ctrl.srcb      = SRCB_IIMM;
               o_ctrl.rf_sel    = RF_MEM;
               o_ctrl.mem_rden2 = 1'b1;
               o_ctrl.rf_we     = 1'b1;
            end else begin
               o_ctrl.illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (w_f3 inside {3'b000, 3'b001, 3'b010}) begin
               o_ctrl.srcb   = SRCB_SIMM;
               o_ctrl.mem_we = 1'b1;
            end else begin
               o_ctrl.illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            case (w_f3)
               3'b000:  w_taken = i_br_eq;
               3'b001:  w_taken = !i_br_eq;
               3'b100:  w_taken = i_br_lt;
               3'b101:  w_taken = !i_br_lt;
               3'b110:  w_taken = i_br_ltu;
               3'b111:  w_taken = !i_br_ltu;
               default: o_ctrl.illegal = 1'b1;
            endcase
            o_ctrl.pc_sel = w_taken ? PC_BRANCH : PC_PLUS4;
         end
         OP_JAL: begin
            o_ctrl.pc_sel = PC_JAL;
            o_ctrl.rf_sel = RF_PC4;
            o_ctrl.rf_we  = 1'b1;
         end
         OP_JALR: begin
            if (w_f3 == 3'b000) begin
               o_ctrl.pc_sel = PC_JALR;
               o_ctrl.rf_sel = RF_PC4;
               o_ctrl.rf_we  = 1'b1;
            end else begin
               o_ctrl.illegal = 1'b1;
            end
         end
         OP_LUI: begin
            o_ctrl.alu_fun = ALU_LUI;
            o_ctrl.srca    = SRCA_UIMM;
            o_ctrl.rf_sel  = RF_ALU;
            o_ctrl.rf_we   = 1'b1;
         end
         OP_AUIPC: begin
            o_ctrl.srca   = SRCA_UIMM;
            o_ctrl.srcb   = SRCB_PC;
            o_ctrl.rf_sel = RF_ALU;
            o_ctrl.rf_we  = 1'b1;
         end
         OP_SYSTEM: begin
            if (!EN_CSR) begin
               o_ctrl.illegal = 1'b1;
            end else if (i_ir == MRET_INSN) begin
               o_ctrl.pc_sel    = PC_MEPC;
               o_ctrl.mret_exec = 1'b1;
            end else if (w_f3 inside {3'b001, 3'b010, 3'b011}) begin
               o_ctrl.rf_sel = RF_CSR;
               o_ctrl.csr_we = 1'b1;
               o_ctrl.rf_we  = 1'b1;
               // CSRRW passes rs1 through the lui-copy path; S/C combine rs1 with the csr.
               case (w_f3)
                  3'b001:  o_ctrl.alu_fun = ALU_LUI;
                  3'b010: begin
                     o_ctrl.alu_fun = ALU_OR;
                     o_ctrl.srcb    = SRCB_CSR;
                  end
                  default: begin
                     o_ctrl.alu_fun = ALU_AND;
                     o_ctrl.srca    = SRCA_NRS1;
                     o_ctrl.srcb    = SRCB_CSR;
                  end
               endcase
            end else begin
               o_ctrl.illegal = 1'b1;
            end
         end
         default: o_ctrl.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/otter_decode_stage.sv
// rtl/otter_decode_stage.sv - registered decode stage: handshake register, interrupt latch, flush
module otter_decode_stage
   import otter_decode_stage_pkg::*;
#(
   parameter int ALU_FUN_W = 4,
   parameter int PC_SEL_W  = 3,
   parameter bit EN_INT    = 1'b1,
   parameter bit EN_CSR    = 1'b1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   otter_decode_stage_if.slave io_dec
);
   ctrl_t r_ctrl;
   logic  r_out_valid;
   logic  r_int_pend;
   ctrl_t w_dec;
   logic  w_in_ready;
   logic  w_capture;
   logic  w_int_pend;

   otter_decode_comb #(.EN_CSR(EN_CSR)) u_comb (
      .i_ir     (io_dec.ir),
      .i_br_eq  (io_dec.br_eq),
      .i_br_lt  (io_dec.br_lt),
      .i_br_ltu (io_dec.br_ltu),
      .o_ctrl   (w_dec)
   );

   assign w_in_ready = !r_out_valid || io_dec.out_ready;
   assign w_capture  = io_dec.in_valid && w_in_ready && !io_dec.flush;
   assign w_int_pend = EN_INT ? r_int_pend : 1'b0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_int_pend  <= 1'b0;
         r_ctrl      <= '0;
      end else begin
         if (io_dec.flush) begin
            r_out_valid <= 1'b0;
         end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_int_pend ? trap_ctrl() : w_dec;
         end else if (io_dec.out_ready) begin
            r_out_valid <= 1'b0;
         end
         // Consumption wins over a same-edge request; a level request re-pends next cycle.
         if (w_capture && w_int_pend) begin
            r_int_pend <= 1'b0;
         end else if (EN_INT && io_dec.int_req) begin
            r_int_pend <= 1'b1;
         end
      end
   end

   assign io_dec.in_ready  = w_in_ready;
   assign io_dec.out_valid = r_out_valid;
   assign io_dec.alu_fun   = ALU_FUN_W'(r_ctrl.alu_fun);
   assign io_dec.srca_sel  = r_ctrl.srca;
   assign io_dec.srcb_sel  = r_ctrl.srcb;
   assign io_dec.pc_sel    = PC_SEL_W'(r_ctrl.pc_sel);
   assign io_dec.rf_sel    = r_ctrl.rf_sel;
   assign io_dec.rf_we     = r_ctrl.rf_we;
   assign io_dec.mem_we    = r_ctrl.mem_we;
   assign io_dec.mem_rden2 = r_ctrl.mem_rden2;
   assign io_dec.csr_we    = r_ctrl.csr_we;
   assign io_dec.mret_exec = r_ctrl.mret_exec;
   assign io_dec.int_taken = r_ctrl.int_taken;
   assign io_dec.illegal   = r_ctrl.illegal;
endmodule

// File: tb/tb_otter_decode_stage.sv
// tb/tb_otter_decode_stage.sv - scoreboard bench for the registered decode stage
module tb_otter_decode_stage;
   typedef struct packed {
      logic [3:0] alu;
      logic [1:0] sa;
      logic [2:0] sb;
      logic [2:0] pc;
      logic [1:0] rf;
      logic [6:0] fl;   // {rf_we, mem_we, mem_rden2, csr_we, mret_exec, int_taken, illegal}
   } exp_t;

   localparam logic [6:0] F_RF = 7'b1000000, F_MEM = 7'b0100000, F_RD = 7'b0010000;
   localparam logic [6:0] F_CSR = 7'b0001000, F_MRET = 7'b0000100, F_INT = 7'b0000010;
   localparam logic [6:0] F_ILL = 7'b0000001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t scb[$];

   otter_decode_stage_if bus ();
   otter_decode_stage dut (.i_clk(clk), .i_rst(rst), .io_dec(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(logic [3:0] alu, logic [1:0] sa, logic [2:0] sb,
                               logic [2:0] pc, logic [1:0] rf, logic [6:0] fl);
      exp_t e;
      e = '{alu: alu, sa: sa, sb: sb, pc: pc, rf: rf, fl: fl};
      return e;
   endfunction

   function automatic logic [6:0] flags();
      return {bus.rf_we, bus.mem_we, bus.mem_rden2, bus.csr_we,
              bus.mret_exec, bus.int_taken, bus.illegal};
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (scb.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = scb.pop_front();
            chk("alu_fun", 32'(bus.alu_fun), 32'(e.alu));
            chk("srca", 32'(bus.srca_sel), 32'(e.sa));
            chk("srcb", 32'(bus.srcb_sel), 32'(e.sb));
            chk("pc_sel", 32'(bus.pc_sel), 32'(e.pc));
            chk("rf_sel", 32'(bus.rf_sel), 32'(e.rf));
            chk("flags", 32'(flags()), 32'(e.fl));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] ir, input logic eq, input logic lt,
                       input logic ltu, input exp_t e);
      bit done;
      done = 1'b0;
      bus.ir = ir; bus.br_eq = eq; bus.br_lt = lt; bus.br_ltu = ltu;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (bus.in_ready && !bus.flush) begin
            scb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && scb.size() != 0; i++) tick(1);
      chk("drain", 32'(scb.size()), 32'd0);
   endtask

   exp_t e_addi, e_trap, e_xor, e_sub;

   initial begin
      e_addi = mk(4'h0, 2'd0, 3'd1, 3'd0, 2'd3, F_RF);
      e_trap = mk(4'h0, 2'd0, 3'd0, 3'd4, 2'd0, F_INT);
      e_xor  = mk(4'h4, 2'd0, 3'd0, 3'd0, 2'd3, F_RF);
      e_sub  = mk(4'h8, 2'd0, 3'd0, 3'd0, 2'd3, F_RF);
      bus.in_valid = 1'b0; bus.ir = 32'h0; bus.br_eq = 1'b0; bus.br_lt = 1'b0;
      bus.br_ltu = 1'b0; bus.int_req = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_pc_alu", {bus.pc_sel, bus.alu_fun}, 32'd0);
      chk("rst_flags", 32'(flags()), 32'd0);
      @(posedge clk); #1;

      send(32'h0062C233, 0, 0, 0, e_xor);
      send(32'h4062D233, 0, 0, 0, mk(4'hD, 2'd0, 3'd0, 3'd0, 2'd3, F_RF));
      send(32'h406282B3, 0, 0, 0, e_sub);
      send(32'h4010D093, 0, 0, 0, mk(4'hD, 2'd0, 3'd1, 3'd0, 2'd3, F_RF));
      send(32'h00628463, 1, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd2, 2'd0, 7'd0));
      send(32'h00628463, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd0, 2'd0, 7'd0));
      send(32'h0062E463, 0, 0, 1, mk(4'h0, 2'd0, 3'd0, 3'd2, 2'd0, 7'd0));
      send(32'h0062D463, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd2, 2'd0, 7'd0));
      send(32'h0062A463, 1, 1, 1, mk(4'h0, 2'd0, 3'd0, 3'd0, 2'd0, F_ILL));
      send(32'h00012083, 0, 0, 0, mk(4'h0, 2'd0, 3'd1, 3'd0, 2'd2, F_RF | F_RD));
      send(32'h00112023, 0, 0, 0, mk(4'h0, 2'd0, 3'd2, 3'd0, 2'd0, F_MEM));
      send(32'h000000EF, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd3, 2'd0, F_RF));
      send(32'h000100E7, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd1, 2'd0, F_RF));
      send(32'h123450B7, 0, 0, 0, mk(4'h9, 2'd1, 3'd0, 3'd0, 2'd3, F_RF));
      send(32'h00000097, 0, 0, 0, mk(4'h0, 2'd1, 3'd3, 3'd0, 2'd3, F_RF));
      send(32'h305110F3, 0, 0, 0, mk(4'h9, 2'd0, 3'd0, 3'd0, 2'd1, F_RF | F_CSR));
      send(32'h300120F3, 0, 0, 0, mk(4'h6, 2'd0, 3'd4, 3'd0, 2'd1, F_RF | F_CSR));
      send(32'h300130F3, 0, 0, 0, mk(4'h7, 2'd2, 3'd4, 3'd0, 2'd1, F_RF | F_CSR));
      send(32'h30200073, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd5, 2'd0, F_MRET));
      send(32'hFFFFFFFF, 0, 0, 0, mk(4'h0, 2'd0, 3'd0, 3'd0, 2'd0, F_ILL));
      drain();

      // back-pressure: held output stable, upstream stalled
      bus.out_ready = 1'b0;
      send(32'h0062C233, 0, 0, 0, e_xor);
      bus.ir = 32'h406282B3; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_alu", 32'(bus.alu_fun), 32'h4);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      scb.push_back(e_sub);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("release_valid", 32'(bus.out_valid), 32'd1);
      chk("release_alu", 32'(bus.alu_fun), 32'h8);
      @(posedge clk); #1;
      drain();

      // interrupt pulse then capture -> trap, next capture normal
      bus.int_req = 1'b1; tick(1); bus.int_req = 1'b0;
      send(32'h00500093, 0, 0, 0, e_trap);
      send(32'h00500093, 0, 0, 0, e_addi);
      // request coincident with a capture leaves that capture alone
      bus.int_req = 1'b1;
      send(32'h00500093, 0, 0, 0, e_addi);
      bus.int_req = 1'b0;
      send(32'h00500093, 0, 0, 0, e_trap);
      send(32'h0062C233, 0, 0, 0, e_xor);
      drain();

      // flush beats holding and capture
      bus.out_ready = 1'b0;
      send(32'h00500093, 0, 0, 0, e_addi);
      bus.ir = 32'h00012083; bus.in_valid = 1'b1; bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      void'(scb.pop_front());
      tick(1);
      chk("flush_nocap", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;

      // reset mid-transaction drops the held trap and the pending interrupt
      bus.out_ready = 1'b0;
      bus.int_req = 1'b1; tick(1); bus.int_req = 1'b0;
      send(32'h00500093, 0, 0, 0, e_trap);
      bus.int_req = 1'b1; tick(1); bus.int_req = 1'b0;
      rst = 1'b1; tick(1); rst = 1'b0;
      void'(scb.pop_front());
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      send(32'h00500093, 0, 0, 0, e_addi);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
